// File: rtl/ag32gbd_pkg.sv
// Shared types and constants for the M64282FP-style sensor responder model.
package ag32gbd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXPOSE  = 2'd1,
        READOUT = 2'd2
    } state_e;

    localparam int unsigned R_EXP_HI  = 2;
    localparam int unsigned R_EXP_LO  = 3;
    localparam int unsigned R_OFFSET  = 7;

    localparam int unsigned DEF_ROWS     = 128;
    localparam int unsigned DEF_COLS     = 128;
    localparam int unsigned DEF_EXP_UNIT = 16;

    localparam int unsigned REG_W     = 8;
    localparam int unsigned ADDR_W    = 3;
    localparam int unsigned NUM_REGS  = 8;
    localparam int unsigned SR_W      = ADDR_W + REG_W;
    localparam int unsigned EXP_CNT_W = 21;
    localparam int unsigned NUM_SYNC  = 4;

    // A programmed exposure of zero behaves like one unit.
    function automatic logic [15:0] exp_at_least_one(input logic [15:0] cnt);
        return (cnt == 16'd0) ? 16'd1 : cnt;
    endfunction

endpackage

// File: rtl/ag32gbd_sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detector on the synchronised value.
module ag32gbd_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_c
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_c = sync_q & ~prev_q;

endmodule

// File: rtl/ag32gbd_sens_model.sv
// Behavioural image-sensor responder: serial register writes, exposure countdown
// and a deterministic pixel stream, all advanced on synchronised XCK rises.
module ag32gbd_sens_model
    import ag32gbd_pkg::*;
#(
    parameter int unsigned ROWS     = DEF_ROWS,
    parameter int unsigned COLS     = DEF_COLS,
    parameter int unsigned EXP_UNIT = DEF_EXP_UNIT
) (
    input  logic              sys_clock,
    input  logic              resetn,
    input  logic              sens_xck,
    input  logic              sens_reset,
    input  logic              sens_load,
    input  logic              sens_sin,
    input  logic              sens_start,
    output logic              sens_read,
    output logic [REG_W-1:0]  pix_data,
    output logic              pix_valid,
    output logic              busy,
    output logic [ADDR_W-1:0] reg_addr_dbg
);

    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    logic                xr_c;
    logic [NUM_SYNC-1:0] meta_q;
    logic [NUM_SYNC-1:0] sync_q;
    logic                sin_s;
    logic                load_s;
    logic                start_s;
    logic                sreset_n_s;

    state_e              state_q,     state_d;
    logic [SR_W-2:0]     sr_q,        sr_d;
    logic [REG_W-1:0]    regs_q [NUM_REGS];
    logic [REG_W-1:0]    regs_d [NUM_REGS];
    logic [EXP_CNT_W-1:0] exp_cnt_q,  exp_cnt_d;
    logic [ROW_W-1:0]    row_q,       row_d;
    logic [COL_W-1:0]    col_q,       col_d;
    logic                sens_read_q, sens_read_d;
    logic [REG_W-1:0]    pix_data_q,  pix_data_d;
    logic                pix_valid_q, pix_valid_d;
    logic                busy_q,      busy_d;
    logic [ADDR_W-1:0]   reg_addr_q,  reg_addr_d;

    logic [SR_W-1:0]     sr_next;
    logic [15:0]         exp_prog;

    ag32gbd_sync_edge u_xck_sync (
        .clk    (sys_clock),
        .rst_n  (resetn),
        .d_i    (sens_xck),
        .rise_c (xr_c)
    );

    // Plain two-flop synchronisers for the level inputs.
    always_ff @(posedge sys_clock or negedge resetn) begin
        if (!resetn) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= {sens_reset, sens_start, sens_load, sens_sin};
            sync_q <= meta_q;
        end
    end

    assign sin_s      = sync_q[0];
    assign load_s     = sync_q[1];
    assign start_s    = sync_q[2];
    assign sreset_n_s = sync_q[3];

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        regs_d      = regs_q;
        exp_cnt_d   = exp_cnt_q;
        row_d       = row_q;
        col_d       = col_q;
        pix_data_d  = pix_data_q;
        pix_valid_d = 1'b0;
        reg_addr_d  = reg_addr_q;
        sr_next     = {sr_q, sin_s};
        exp_prog    = 16'd0;

        if (!sreset_n_s) begin
            state_d   = IDLE;
            sr_d      = '0;
            exp_cnt_d = '0;
            row_d     = '0;
            col_d     = '0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_d[i] = '0;
            end
        end else if (xr_c) begin
            case (state_q)
                IDLE: begin
                    sr_d = sr_next[SR_W-2:0];
                    if (load_s) begin
                        regs_d[sr_next[SR_W-1:REG_W]] = sr_next[REG_W-1:0];
                        reg_addr_d                    = sr_next[SR_W-1:REG_W];
                    end
                    // Exposure length sees a register write landing on the same rise.
                    if (start_s) begin
                        exp_prog  = exp_at_least_one({regs_d[R_EXP_HI], regs_d[R_EXP_LO]});
                        exp_cnt_d = EXP_CNT_W'(EXP_UNIT) * EXP_CNT_W'(exp_prog);
                        state_d   = EXPOSE;
                    end
                end
                EXPOSE: begin
                    exp_cnt_d = exp_cnt_q - EXP_CNT_W'(1);
                    if (exp_cnt_q == EXP_CNT_W'(1)) begin
                        state_d = READOUT;
                        row_d   = '0;
                        col_d   = '0;
                    end
                end
                READOUT: begin
                    pix_data_d  = REG_W'(row_q) + REG_W'(col_q) + regs_q[R_OFFSET];
                    pix_valid_d = 1'b1;
                    if (col_q == COL_W'(COLS - 1)) begin
                        col_d = '0;
                        if (row_q == ROW_W'(ROWS - 1)) begin
                            row_d   = '0;
                            state_d = IDLE;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        sens_read_d = (state_d == READOUT);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge sys_clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            exp_cnt_q   <= '0;
            row_q       <= '0;
            col_q       <= '0;
            sens_read_q <= 1'b0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            reg_addr_q  <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            exp_cnt_q   <= exp_cnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            sens_read_q <= sens_read_d;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
            busy_q      <= busy_d;
            reg_addr_q  <= reg_addr_d;
            regs_q      <= regs_d;
        end
    end

    assign sens_read    = sens_read_q;
    assign pix_data     = pix_data_q;
    assign pix_valid    = pix_valid_q;
    assign busy         = busy_q;
    assign reg_addr_dbg = reg_addr_q;

endmodule

// File: tb/tb_ag32gbd_sens_model.sv
// Directed bench for ag32gbd_sens_model with a pixel scoreboard fed by the stimulus.
module tb_ag32gbd_sens_model;

    logic       sys_clock = 1'b0;
    logic       resetn;
    logic       sens_xck;
    logic       sens_reset;
    logic       sens_load;
    logic       sens_sin;
    logic       sens_start;
    logic       sens_read;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic       busy;
    logic [2:0] reg_addr_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int n_pix    = 0;

    logic [7:0] exp_q [$];
    int         mrow;
    int         mcol;
    logic [7:0] moff;

    always #5 sys_clock = ~sys_clock;

    ag32gbd_sens_model dut (
        .sys_clock    (sys_clock),
        .resetn       (resetn),
        .sens_xck     (sens_xck),
        .sens_reset   (sens_reset),
        .sens_load    (sens_load),
        .sens_sin     (sens_sin),
        .sens_start   (sens_start),
        .sens_read    (sens_read),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .busy         (busy),
        .reg_addr_dbg (reg_addr_dbg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Pops one expected pixel per strobe; a strobe with nothing pending is an error.
    always @(negedge sys_clock) begin
        if (pix_valid === 1'b1) begin
            n_pix++;
            check("pix_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("pix_data", 32'(pix_data), 32'(e));
            end
        end
    end

    // One XCK period of four sys_clock cycles; entered and left on a falling sys_clock edge.
    task automatic xck_pulse(input logic sin, input logic load, input logic start);
        sens_sin   = sin;
        sens_load  = load;
        sens_start = start;
        sens_xck   = 1'b1;
        repeat (2) @(negedge sys_clock);
        sens_xck   = 1'b0;
        sens_load  = 1'b0;
        sens_start = 1'b0;
        repeat (2) @(negedge sys_clock);
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
        logic [10:0] w;
        w = {a, d};
        for (int i = 10; i >= 0; i--) begin
            xck_pulse(w[i], (i == 0), 1'b0);
        end
    endtask

    // Pulses until sens_read rises, bounded so a stuck exposure still reaches the summary.
    task automatic expose_count(output int n);
        n = 0;
        while (sens_read !== 1'b1 && n < 200) begin
            xck_pulse(1'b0, 1'b0, 1'b0);
            n++;
        end
    endtask

    // Readout pulse: the model's pixel is queued before the edge that emits it.
    task automatic pix_pulse(input logic sin, input logic load, input logic start);
        exp_q.push_back(8'(mrow + mcol) + moff);
        xck_pulse(sin, load, start);
        if (mcol == 127) begin
            mcol = 0;
            mrow = (mrow == 127) ? 0 : mrow + 1;
        end else begin
            mcol++;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int base;
        logic [10:0] wr;

        resetn     = 1'b0;
        sens_xck   = 1'b0;
        sens_reset = 1'b1;
        sens_load  = 1'b0;
        sens_sin   = 1'b0;
        sens_start = 1'b0;
        repeat (3) @(negedge sys_clock);
        check("rst_sens_read", 32'(sens_read), 32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_pix_data", 32'(pix_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_reg_addr", 32'(reg_addr_dbg), 32'd0);
        resetn = 1'b1;
        repeat (4) @(negedge sys_clock);

        // Exposure of 2 units, pixel offset 0x10.
        write_reg(3'b010, 8'h00);
        check("addr_after_r2", 32'(reg_addr_dbg), 32'd2);
        write_reg(3'b011, 8'h02);
        check("addr_after_r3", 32'(reg_addr_dbg), 32'd3);
        write_reg(3'b111, 8'h10);
        check("addr_after_r7", 32'(reg_addr_dbg), 32'd7);

        xck_pulse(1'b0, 1'b0, 1'b1);
        check("start_busy", 32'(busy), 32'd1);
        check("start_read_low", 32'(sens_read), 32'd0);
        expose_count(n);
        check("expose_xr_count", 32'(n), 32'd32);

        // Full frame.
        mrow = 0; mcol = 0; moff = 8'h10;
        base = n_pix;
        for (int p = 0; p < 128 * 128; p++) begin
            pix_pulse(1'b0, 1'b0, 1'b0);
        end
        check("frame_pix_count", 32'(n_pix - base), 32'd16384);
        check("frame_end_read", 32'(sens_read), 32'd0);
        check("frame_end_busy", 32'(busy), 32'd0);
        check("frame_last_hold", 32'(pix_data), 32'h0E);
        check("frame_queue_empty", 32'(exp_q.size()), 32'd0);

        // Second frame: writes and START during readout must not disturb the stream.
        xck_pulse(1'b0, 1'b0, 1'b1);
        expose_count(n);
        check("expose2_xr_count", 32'(n), 32'd32);
        mrow = 0; mcol = 0;
        wr = {3'b111, 8'h55};
        for (int p = 0; p < 500; p++) begin
            if (p >= 100 && p <= 110)
                pix_pulse(wr[110 - p], (p == 110), 1'b0);
            else
                pix_pulse(1'b0, 1'b0, (p == 120));
        end
        check("ignore_busy", 32'(busy), 32'd1);
        check("ignore_read", 32'(sens_read), 32'd1);

        // Sensor reset mid-readout.
        sens_reset = 1'b0;
        repeat (3) @(negedge sys_clock);
        check("sreset_read", 32'(sens_read), 32'd0);
        check("sreset_busy", 32'(busy), 32'd0);
        base = n_pix;
        for (int p = 0; p < 4; p++) xck_pulse(1'b0, 1'b0, 1'b0);
        check("sreset_no_pix", 32'(n_pix - base), 32'd0);
        sens_reset = 1'b1;
        repeat (4) @(negedge sys_clock);

        // Cleared registers: zero exposure acts as one unit, offset back to 0.
        xck_pulse(1'b0, 1'b0, 1'b1);
        expose_count(n);
        check("expose_zero_xr_count", 32'(n), 32'd16);
        mrow = 0; mcol = 0; moff = 8'h00;
        pix_pulse(1'b0, 1'b0, 1'b0);
        pix_pulse(1'b0, 1'b0, 1'b0);
        check("new_frame_pix1", 32'(pix_data), 32'h01);

        // Back to idle, start an exposure and pull resetn part way through.
        sens_reset = 1'b0;
        repeat (3) @(negedge sys_clock);
        sens_reset = 1'b1;
        repeat (4) @(negedge sys_clock);
        xck_pulse(1'b0, 1'b0, 1'b1);
        for (int p = 0; p < 5; p++) xck_pulse(1'b0, 1'b0, 1'b0);
        check("mid_expose_busy", 32'(busy), 32'd1);
        resetn = 1'b0;
        #1;
        check("async_busy", 32'(busy), 32'd0);
        check("async_read", 32'(sens_read), 32'd0);
        check("async_pix_data", 32'(pix_data), 32'd0);
        check("async_pix_valid", 32'(pix_valid), 32'd0);
        check("async_reg_addr", 32'(reg_addr_dbg), 32'd0);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
